// File: rtl/mem_pkg.sv
// Shared definitions for the CPU-facing memory/I/O slave: bus commands,
// default I/O addresses and FSM state encoding.
package mem_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned RAM_AW     = 8;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [ADDR_W_DEF-1:0] LED_ADDR_DEF = 9'h100;
  localparam logic [ADDR_W_DEF-1:0] SW_ADDR_DEF  = 9'h140;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRdWait = 2'b01,
    StRdDone = 2'b10
  } state_e;

endpackage

// File: rtl/ram_sync.sv
// Single-port synchronous RAM, write-first, registered read output.
// Contents are intentionally not reset.
module ram_sync #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned AW     = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<AW)-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
      r_rdata       <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_io_bus.sv
// Memory and I/O slave behind the CPU memory port: 256x16 RAM, LED register,
// synchronised switch port, mem_ready handshake and a sticky error flag.
module mem_io_bus
  import mem_pkg::*;
#(
  parameter int unsigned        DATA_W   = DATA_W_DEF,
  parameter int unsigned        ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0]  LED_ADDR = LED_ADDR_DEF,
  parameter logic [ADDR_W-1:0]  SW_ADDR  = SW_ADDR_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [1:0]        i_mem_cmd,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_write_data,
  output logic [DATA_W-1:0] o_read_data,
  output logic              o_mem_ready,
  input  logic [9:0]        i_sw,
  output logic [7:0]        o_led,
  output logic              o_err
);

  state_e              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_read_data;
  logic [7:0]          r_led;
  logic                r_err;
  logic [9:0]          r_sw_meta, r_sw_sync;

  logic                w_capture;
  logic                w_wr;
  logic                w_ram_we;
  logic                w_led_we;
  logic                w_wr_err;
  logic                w_rd_err;
  logic [DATA_W-1:0]   w_rd_value;
  logic [DATA_W-1:0]   w_ram_rdata;

  // Writes commit in any state that is not waiting on a read.
  assign w_wr     = (i_mem_cmd == MEM_WRITE) && (r_state != StRdWait);
  assign w_ram_we = w_wr && !i_mem_addr[ADDR_W-1];
  assign w_led_we = w_wr && (i_mem_addr == LED_ADDR);
  assign w_wr_err = w_wr && i_mem_addr[ADDR_W-1] && (i_mem_addr != LED_ADDR);

  ram_sync #(
    .DATA_W (DATA_W),
    .AW     (RAM_AW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_ram_we),
    .i_addr  (i_mem_addr[RAM_AW-1:0]),
    .i_wdata (i_write_data),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_rd_value = '0;
    w_rd_err   = 1'b0;
    if (!r_addr[ADDR_W-1]) begin
      w_rd_value = w_ram_rdata;
    end else if (r_addr == LED_ADDR) begin
      w_rd_value = DATA_W'(r_led);
    end else if (r_addr == SW_ADDR) begin
      w_rd_value = DATA_W'(r_sw_sync);
    end else begin
      w_rd_err = (r_state == StRdWait);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_mem_cmd == MEM_READ) begin
          w_state_next = StRdWait;
          w_capture    = 1'b1;
        end
      end
      StRdWait: w_state_next = StRdDone;
      StRdDone: begin
        if (i_mem_cmd == MEM_READ) begin
          if (i_mem_addr != r_addr) begin
            w_state_next = StRdWait;
            w_capture    = 1'b1;
          end
        end else begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_read_data <= '0;
      r_led       <= '0;
      r_err       <= 1'b0;
      r_sw_meta   <= '0;
      r_sw_sync   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_sw_meta <= i_sw;
      r_sw_sync <= r_sw_meta;
      r_err     <= r_err | w_wr_err | w_rd_err;
      if (w_capture) r_addr <= i_mem_addr;
      if (r_state == StRdWait) r_read_data <= w_rd_value;
      if (w_led_we) r_led <= i_write_data[7:0];
    end
  end

  assign o_mem_ready = (r_state == StRdDone) || w_wr;
  assign o_read_data = r_read_data;
  assign o_led       = r_led;
  assign o_err       = r_err;

endmodule

// File: tb/tb_mem_io_bus.sv
// Self-checking bench for mem_io_bus: directed vector table, hand-written
// reset/switch/error sequences, and randomized traffic against a model.
module tb_mem_io_bus;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cmd;
  logic [8:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ready;
  logic [9:0]  sw;
  logic [7:0]  led;
  logic        err;

  int checks = 0;
  int failures = 0;

  logic [15:0] m_mem [0:255];
  logic [7:0]  m_led;
  logic        m_err;
  logic [9:0]  m_sw;

  always #5 clk = ~clk;

  mem_io_bus #(
    .DATA_W   (16),
    .ADDR_W   (9),
    .LED_ADDR (9'h100),
    .SW_ADDR  (9'h140)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_mem_cmd    (cmd),
    .i_mem_addr   (addr),
    .i_write_data (wdata),
    .o_read_data  (rdata),
    .o_mem_ready  (ready),
    .i_sw         (sw),
    .o_led        (led),
    .o_err        (err)
  );

  typedef struct packed {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wd;
    logic        rdy;
    logic [15:0] rd;
    logic [7:0]  led;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d,
                             input logic r, input logic [15:0] rd, input logic [7:0] l,
                             input logic e);
    vec_t t;
    t.cmd = c; t.addr = a; t.wd = d; t.rdy = r; t.rd = rd; t.led = l; t.err = e;
    return t;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
    cmd = c; addr = a; wdata = d;
    #1;
  endtask

  function automatic logic [15:0] model_read(input logic [8:0] a);
    if (!a[8])          return m_mem[a[7:0]];
    else if (a == 9'h100) return {8'h00, m_led};
    else if (a == 9'h140) return {6'b0, m_sw};
    m_err = 1'b1;
    return 16'h0000;
  endfunction

  // Present a held READ from IDLE, expect ready after exactly two edges.
  task automatic read_txn(input logic [8:0] a, input logic [15:0] exp, input string name);
    int n = 0;
    drive(MEM_READ, a, 16'h0);
    check({name, "_ready_idle"}, {15'b0, ready}, 16'h0);
    while (n < 6 && !ready) begin
      tick();
      n++;
      drive(MEM_READ, a, 16'h0);
    end
    check({name, "_latency"}, 16'(n), 16'd2);
    check({name, "_data"}, rdata, exp);
    check({name, "_err"}, {15'b0, err}, {15'b0, m_err});
    drive(MEM_NONE, 9'h0, 16'h0);
    tick();
  endtask

  task automatic write_txn(input logic [8:0] a, input logic [15:0] d, input string name);
    drive(MEM_WRITE, a, d);
    check({name, "_ready"}, {15'b0, ready}, 16'h1);
    tick();
    drive(MEM_NONE, 9'h0, 16'h0);
    if (!a[8])             m_mem[a[7:0]] = d;
    else if (a == 9'h100)  m_led = d[7:0];
    else                   m_err = 1'b1;
    check({name, "_led"}, {8'h0, led}, {8'h0, m_led});
    check({name, "_err"}, {15'b0, err}, {15'b0, m_err});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(MEM_NONE, 9'h0, 16'h0);
    tick();
    tick();
    rst_n = 1'b1;
    m_led = 8'h00;
    m_err = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0]  ra;
    logic [15:0] rd;
    sw = 10'h000;
    m_sw = 10'h000;
    cmd = MEM_NONE; addr = '0; wdata = '0;
    rst_n = 1'b0;
    #1;
    check("reset_rdata", rdata, 16'h0);
    check("reset_ready", {15'b0, ready}, 16'h0);
    check("reset_led", {8'h0, led}, 16'h0);
    check("reset_err", {15'b0, err}, 16'h0);
    tick();
    tick();
    rst_n = 1'b1;

    tbl.push_back(v(MEM_WRITE, 9'h005, 16'hBEEF, 1, 16'h0000, 8'h00, 0));
    tbl.push_back(v(MEM_READ,  9'h005, 16'h0,    0, 16'h0000, 8'h00, 0));
    tbl.push_back(v(MEM_READ,  9'h005, 16'h0,    0, 16'h0000, 8'h00, 0));
    tbl.push_back(v(MEM_READ,  9'h005, 16'h0,    1, 16'hBEEF, 8'h00, 0));
    tbl.push_back(v(MEM_NONE,  9'h000, 16'h0,    1, 16'hBEEF, 8'h00, 0));
    tbl.push_back(v(MEM_WRITE, 9'h003, 16'h1111, 1, 16'hBEEF, 8'h00, 0));
    tbl.push_back(v(MEM_WRITE, 9'h004, 16'h2222, 1, 16'hBEEF, 8'h00, 0));
    tbl.push_back(v(MEM_READ,  9'h003, 16'h0,    0, 16'hBEEF, 8'h00, 0));
    tbl.push_back(v(MEM_READ,  9'h003, 16'h0,    0, 16'hBEEF, 8'h00, 0));
    tbl.push_back(v(MEM_READ,  9'h003, 16'h0,    1, 16'h1111, 8'h00, 0));
    tbl.push_back(v(MEM_READ,  9'h003, 16'h0,    1, 16'h1111, 8'h00, 0));
    tbl.push_back(v(MEM_READ,  9'h004, 16'h0,    1, 16'h1111, 8'h00, 0));
    tbl.push_back(v(MEM_READ,  9'h004, 16'h0,    0, 16'h1111, 8'h00, 0));
    tbl.push_back(v(MEM_READ,  9'h004, 16'h0,    1, 16'h2222, 8'h00, 0));
    tbl.push_back(v(MEM_WRITE, 9'h100, 16'h12A5, 1, 16'h2222, 8'h00, 0));
    tbl.push_back(v(MEM_READ,  9'h100, 16'h0,    0, 16'h2222, 8'hA5, 0));
    tbl.push_back(v(MEM_READ,  9'h100, 16'h0,    0, 16'h2222, 8'hA5, 0));
    tbl.push_back(v(MEM_READ,  9'h100, 16'h0,    1, 16'h00A5, 8'hA5, 0));
    tbl.push_back(v(2'b11,     9'h005, 16'hFFFF, 1, 16'h00A5, 8'hA5, 0));
    tbl.push_back(v(2'b11,     9'h005, 16'hFFFF, 0, 16'h00A5, 8'hA5, 0));
    tbl.push_back(v(MEM_READ,  9'h005, 16'h0,    0, 16'h00A5, 8'hA5, 0));
    tbl.push_back(v(MEM_READ,  9'h005, 16'h0,    0, 16'h00A5, 8'hA5, 0));
    tbl.push_back(v(MEM_READ,  9'h005, 16'h0,    1, 16'hBEEF, 8'hA5, 0));
    tbl.push_back(v(MEM_NONE,  9'h000, 16'h0,    1, 16'hBEEF, 8'hA5, 0));
    tbl.push_back(v(MEM_READ,  9'h1FF, 16'h0,    0, 16'hBEEF, 8'hA5, 0));
    tbl.push_back(v(MEM_READ,  9'h1FF, 16'h0,    0, 16'hBEEF, 8'hA5, 0));
    tbl.push_back(v(MEM_READ,  9'h1FF, 16'h0,    1, 16'h0000, 8'hA5, 1));
    tbl.push_back(v(MEM_NONE,  9'h000, 16'h0,    1, 16'h0000, 8'hA5, 1));
    tbl.push_back(v(MEM_NONE,  9'h000, 16'h0,    0, 16'h0000, 8'hA5, 1));
    tbl.push_back(v(MEM_WRITE, 9'h007, 16'hCAFE, 1, 16'h0000, 8'hA5, 1));
    tbl.push_back(v(MEM_READ,  9'h007, 16'h0,    0, 16'h0000, 8'hA5, 1));
    tbl.push_back(v(MEM_READ,  9'h007, 16'h0,    0, 16'h0000, 8'hA5, 1));
    tbl.push_back(v(MEM_READ,  9'h007, 16'h0,    1, 16'hCAFE, 8'hA5, 1));
    tbl.push_back(v(MEM_NONE,  9'h000, 16'h0,    1, 16'hCAFE, 8'hA5, 1));

    foreach (tbl[i]) begin
      drive(tbl[i].cmd, tbl[i].addr, tbl[i].wd);
      check($sformatf("vec%0d_ready", i), {15'b0, ready}, {15'b0, tbl[i].rdy});
      check($sformatf("vec%0d_rdata", i), rdata, tbl[i].rd);
      check($sformatf("vec%0d_led", i), {8'h0, led}, {8'h0, tbl[i].led});
      check($sformatf("vec%0d_err", i), {15'b0, err}, {15'b0, tbl[i].err});
      tick();
    end
    m_mem[3] = 16'h1111; m_mem[4] = 16'h2222; m_mem[5] = 16'hBEEF; m_mem[7] = 16'hCAFE;

    // Reset while a read is in flight.
    drive(MEM_READ, 9'h005, 16'h0);
    tick();
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_rdata", rdata, 16'h0);
    check("rst_mid_ready", {15'b0, ready}, 16'h0);
    check("rst_mid_led", {8'h0, led}, 16'h0);
    check("rst_mid_err", {15'b0, err}, 16'h0);
    drive(MEM_NONE, 9'h0, 16'h0);
    tick();
    tick();
    rst_n = 1'b1;
    m_led = 8'h00;
    m_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(MEM_NONE, 9'h0, 16'h0);
      check($sformatf("rst_release_ready%0d", i), {15'b0, ready}, 16'h0);
      check($sformatf("rst_release_rdata%0d", i), rdata, 16'h0);
      tick();
    end

    // Switch synchroniser latency.
    sw = 10'h2C3;
    tick(); tick(); tick();
    m_sw = 10'h2C3;
    read_txn(9'h140, 16'h02C3, "sw_read");
    sw = 10'h155;
    read_txn(9'h140, 16'h02C3, "sw_stale");
    tick(); tick(); tick();
    m_sw = 10'h155;
    read_txn(9'h140, 16'h0155, "sw_new");

    // Write to the switch port is ignored but flags an error.
    write_txn(9'h140, 16'hFFFF, "sw_write");
    read_txn(9'h140, 16'h0155, "sw_after_write");
    for (int i = 0; i < 5; i++) tick();
    check("err_sticky", {15'b0, err}, 16'h1);

    // Randomized traffic against the model.
    do_reset();
    for (int a = 0; a < 16; a++) write_txn(9'(a), 16'($urandom), "pre_wr");
    for (int it = 0; it < 250; it++) begin
      int op = int'($urandom_range(0, 9));
      if (op <= 2) begin
        write_txn(9'($urandom_range(0, 15)), 16'($urandom), "rnd_ram_wr");
      end else if (op == 3) begin
        write_txn(9'h100, 16'($urandom), "rnd_led_wr");
      end else if (op == 4) begin
        ra = 9'h101 + 9'($urandom_range(0, 254));
        if ($urandom_range(0, 1) == 0) ra = 9'h140;
        write_txn(ra, 16'($urandom), "rnd_bad_wr");
      end else if (op <= 7) begin
        ra = 9'($urandom_range(0, 15));
        rd = model_read(ra);
        read_txn(ra, rd, "rnd_ram_rd");
      end else if (op == 8) begin
        unique case ($urandom_range(0, 2))
          0: ra = 9'h100;
          1: ra = 9'h140;
          default: begin
            ra = 9'h101 + 9'($urandom_range(0, 254));
            if (ra == 9'h140) ra = 9'h1FF;
          end
        endcase
        rd = model_read(ra);
        read_txn(ra, rd, "rnd_io_rd");
      end else begin
        drive(2'b11, 9'($urandom), 16'($urandom));
        check("rnd_illegal_ready", {15'b0, ready}, 16'h0);
        sw = 10'($urandom);
        tick();
        drive(MEM_NONE, 9'h0, 16'h0);
        check("rnd_illegal_err", {15'b0, err}, {15'b0, m_err});
        check("rnd_illegal_led", {8'h0, led}, {8'h0, m_led});
        tick(); tick();
        m_sw = sw;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_io_bus.md
Name: mem_io_bus

Overview:
- Memory and I/O slave that sits directly downstream of the CPU's memory port.
- Consumes the CPU's mem_cmd, mem_addr and write_data, and returns read_data.
- Contains a 256x16 synchronous RAM, an LED output register and a synchronised switch input port.
- Adds a mem_ready handshake so the CPU FSM knows exactly when read data is valid.

Parameters:
- DATA_W, 16, data bus width
- ADDR_W, 9, address width (matches mem_addr)
- LED_ADDR, 9'h100, address of the LED register
- SW_ADDR, 9'h140, address of the switch port

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (reset=0 resets)
- mem_cmd  in  2  00 NONE, 01 READ, 10 WRITE, 11 illegal
- mem_addr  in  ADDR_W  word address from the CPU
- write_data  in  DATA_W  store data from the CPU
- read_data  out  DATA_W  registered load data
- mem_ready  out  1  read data valid, or write accepted
- sw  in  10  board switches (asynchronous)
- led  out  8  LED register contents
- err  out  1  sticky error flag

Behaviour:
- Reset, asynchronous with reset=0:
  - state=IDLE, read_data=0, mem_ready=0, led=0, err=0, switch synchroniser=0.
  - RAM contents are not reset.
- Address decode:
  - mem_addr[8]==0: RAM word mem_addr[7:0].
  - ==LED_ADDR: LED register.
  - ==SW_ADDR: switch port.
  - Anything else: unmapped.
- Switches pass through a 2-flop synchroniser. A switch read returns {6'b0, sw_sync}, giving 2 cycles of input latency.
- FSM states: IDLE, RD_WAIT, RD_DONE.
  - IDLE:
    - On READ, capture the address and go to RD_WAIT.
    - On WRITE, commit at this edge and stay in IDLE.
    - On NONE or 11, stay in IDLE.
  - RD_WAIT:
    - Always goes to RD_DONE next edge; mem_cmd is ignored. RAM output, LED or switch value is loaded into read_data at this edge.
  - RD_DONE:
    - mem_ready=1 and read_data is valid.
    - READ at the same address: stay, read_data held.
    - READ at a different address: capture it and go to RD_WAIT.
    - WRITE: commit and go to IDLE.
    - NONE or 11: go to IDLE.
- Read latency:
  - A READ presented at edge k gives read_data valid and mem_ready=1 in the cycle after edge k+1.
  - The CPU holds mem_cmd and mem_addr until mem_ready.
- Writes:
  - Committed on the edge where mem_cmd==WRITE in IDLE or RD_DONE.
  - mem_ready=1 combinationally while WRITE is presented in those states.
  - A held WRITE rewrites the same data, which is harmless.
  - LED write: led <= write_data[7:0].
- read_data holds its last value whenever it is not being updated.
- Read-after-write: a write at edge k followed by a read issued at edge k+1 returns the new data. RAM is write-first, with no bypass required.
- Errors (err sets and stays 1 until reset):
  - Unmapped read: read_data=0.
  - Write to SW_ADDR or to an unmapped address: ignored.
  - mem_cmd==11: treated as NONE.
- Reset mid-read: aborts immediately, with no mem_ready pulse after release.

Decomposition:
- Shared package mem_pkg holds:
  - MEM_NONE, MEM_READ, MEM_WRITE command constants;
  - LED_ADDR and SW_ADDR defaults;
  - the FSM state encodings.
- One sub-module, ram_sync: single-port synchronous 256x16 RAM with write-first behaviour and registered output.

Test Plan:
- Reset and defaults: hold reset=0 mid-read, then release -> read_data=0, led=0, err=0, mem_ready=0, state IDLE, no stale mem_ready pulse.
- RAM round trip: WRITE 16'hBEEF at 9'h005, then READ 9'h005 -> mem_ready=1 exactly 2 edges after READ is presented, read_data=16'hBEEF.
- Back-to-back reads: hold READ 9'h003 through RD_DONE, then switch to READ 9'h004 without NONE -> read_data stable at RAM[3], then RD_WAIT, then RAM[4] with mem_ready re-asserted.
- LED: WRITE 16'h12A5 to 9'h100 -> led=8'hA5 next cycle; READ 9'h100 -> read_data=16'h00A5.
- Switches: sw=10'h2C3 stable, wait 2 cycles, READ 9'h140 -> read_data=16'h02C3. Change sw and read immediately -> old value returned.
- Errors: WRITE to 9'h140 -> err=1, sw read unchanged. READ 9'h1FF -> read_data=0. mem_cmd=11 -> no state change. err stays 1 until reset.
